hsem_irq_rsp: RTL and testbench

Core-side responder for the HSEM interrupt/error block. It watches one HSEM core interrupt line, reads the HSEM interrupt (and optionally error) status registers over an AHB-lite master port, and presents the captured cause to the local core as a valid/ready event. After the core accepts the event (or a timeout expires), it writes the HSEM clear registers. One instance is placed per core, between the HSEM slave and the core's interrupt controller.

---
 rtl/hsem_irq_rsp.sv | 228 ++++++++++++++++++++++
 tb/tb_hsem_irq_rsp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hsem_irq_rsp.sv
// HSEM interrupt responder: reads HSEM status over AHB-lite, raises a core event, then clears HSEM.
// Define HSEM_IRQ_ERR_READ_EN to also read and clear the HSEM error register.
module hsem_irq_rsp #(
    parameter logic [31:0] INT_REG_ADDR = 32'h0000_0010,
    parameter logic [31:0] INT_CLR_ADDR = 32'h0000_0014,
    parameter logic [31:0] ERR_REG_ADDR = 32'h0000_0018,
    parameter logic [31:0] ERR_CLR_ADDR = 32'h0000_001C,
    parameter logic [31:0] INTR_MATCH   = 32'h0000_0001,
    parameter int          EVT_TIMEOUT  = 256
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        intr_in,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [31:0] evt_intr,
    output logic [31:0] evt_err,
    output logic [1:0]  evt_cause,
    output logic        evt_dropped,
    output logic        bus_err
);

    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;
    localparam logic [15:0] CNT_LAST  = 16'(EVT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_INT_A,
        S_RD_INT_D,
        S_EVT,
        S_WR_CLR_A,
        S_WR_CLR_D
`ifdef HSEM_IRQ_ERR_READ_EN
        ,
        S_RD_ERR_A,
        S_RD_ERR_D,
        S_WR_ERR_A,
        S_WR_ERR_D
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        intr_q, intr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] evt_intr_q, evt_intr_d;
    logic        match_q, match_d;
    logic        intr_edge;

`ifdef HSEM_IRQ_ERR_READ_EN
    logic [31:0] evt_err_q, evt_err_d;
    logic        err_nz_q, err_nz_d;
`else
    logic        unused_cfg;
    assign unused_cfg = ^{ERR_REG_ADDR, ERR_CLR_ADDR};
`endif

    assign hsize     = 3'b010;
    assign intr_d    = intr_in;
    assign intr_edge = intr_in & ~intr_q;
    assign evt_intr  = evt_intr_q;

`ifdef HSEM_IRQ_ERR_READ_EN
    assign evt_err   = evt_err_q;
    assign evt_cause = {match_q, err_nz_q};
`else
    assign evt_err   = '0;
    assign evt_cause = {match_q, 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cnt_d       = '0;
        evt_intr_d  = evt_intr_q;
        match_d     = match_q;
`ifdef HSEM_IRQ_ERR_READ_EN
        evt_err_d   = evt_err_q;
        err_nz_d    = err_nz_q;
`endif
        htrans      = HT_IDLE;
        haddr       = '0;
        hwrite      = 1'b0;
        hwdata      = '0;
        evt_valid   = 1'b0;
        evt_dropped = 1'b0;
        bus_err     = 1'b0;

        if (intr_edge) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (intr_edge || pending_q) begin
                    state_d   = S_RD_INT_A;
                    pending_d = 1'b0;
                end
            end
            S_RD_INT_A: begin
                htrans = HT_NONSEQ;
                haddr  = INT_REG_ADDR;
                if (hready) state_d = S_RD_INT_D;
            end
            S_RD_INT_D: begin
                if (hready && hresp) begin
                    bus_err   = 1'b1;
                    pending_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (hready) begin
                    evt_intr_d = hrdata;
                    match_d    = (hrdata == INTR_MATCH);
`ifdef HSEM_IRQ_ERR_READ_EN
                    state_d    = S_RD_ERR_A;
`else
                    state_d    = S_EVT;
`endif
                end
            end
`ifdef HSEM_IRQ_ERR_READ_EN
            S_RD_ERR_A: begin
                htrans = HT_NONSEQ;
                haddr  = ERR_REG_ADDR;
                if (hready) state_d = S_RD_ERR_D;
            end
            S_RD_ERR_D: begin
                if (hready && hresp) begin
                    bus_err   = 1'b1;
                    pending_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (hready) begin
                    evt_err_d = hrdata;
                    err_nz_d  = (hrdata != '0);
                    state_d   = S_EVT;
                end
            end
`endif
            S_EVT: begin
                // Counter starts at 0 on entry; last allowed cycle is CNT_LAST.
                evt_valid = 1'b1;
                cnt_d     = cnt_q + 16'd1;
                if (evt_ready) begin
                    state_d = S_WR_CLR_A;
                end else if (cnt_q == CNT_LAST) begin
                    evt_dropped = 1'b1;
                    state_d     = S_WR_CLR_A;
                end
            end
            S_WR_CLR_A: begin
                htrans = HT_NONSEQ;
                haddr  = INT_CLR_ADDR;
                hwrite = 1'b1;
                if (hready) state_d = S_WR_CLR_D;
            end
            S_WR_CLR_D: begin
                hwdata = 32'h0000_0001;
                if (hready && hresp) begin
                    bus_err   = 1'b1;
                    pending_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (hready) begin
`ifdef HSEM_IRQ_ERR_READ_EN
                    state_d = S_WR_ERR_A;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef HSEM_IRQ_ERR_READ_EN
            S_WR_ERR_A: begin
                htrans = HT_NONSEQ;
                haddr  = ERR_CLR_ADDR;
                hwrite = 1'b1;
                if (hready) state_d = S_WR_ERR_D;
            end
            S_WR_ERR_D: begin
                hwdata = 32'h0000_0001;
                if (hready && hresp) begin
                    bus_err   = 1'b1;
                    pending_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (hready) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            intr_q     <= 1'b0;
            cnt_q      <= '0;
            evt_intr_q <= '0;
            match_q    <= 1'b0;
`ifdef HSEM_IRQ_ERR_READ_EN
            evt_err_q  <= '0;
            err_nz_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            intr_q     <= intr_d;
            cnt_q      <= cnt_d;
            evt_intr_q <= evt_intr_d;
            match_q    <= match_d;
`ifdef HSEM_IRQ_ERR_READ_EN
            evt_err_q  <= evt_err_d;
            err_nz_q   <= err_nz_d;
`endif
        end
    end

endmodule

// File: tb/tb_hsem_irq_rsp.sv
// Directed bench for hsem_irq_rsp with a tiny AHB read-data responder.
// Expectations follow whether HSEM_IRQ_ERR_READ_EN is defined.
module tb_hsem_irq_rsp;

`ifdef HSEM_IRQ_ERR_READ_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam int XE = ERR ? 2 : 0;

    logic        hclk = 1'b0;
    logic        hreset, intr_in, hready, hresp, evt_ready;
    logic [31:0] hrdata, haddr, hwdata, evt_intr, evt_err;
    logic [1:0]  htrans, evt_cause;
    logic        hwrite, evt_valid, evt_dropped, bus_err;
    logic [2:0]  hsize;

    logic [31:0] rd_int, rd_err, dph_addr;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n0;

    hsem_irq_rsp #(.EVT_TIMEOUT(4)) dut (
        .hclk(hclk), .hreset(hreset), .intr_in(intr_in),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_intr(evt_intr),
        .evt_err(evt_err), .evt_cause(evt_cause),
        .evt_dropped(evt_dropped), .bus_err(bus_err)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Slave model: remember the accepted address, return data for it.
    always @(posedge hclk) begin
        if (hreset) dph_addr <= '0;
        else if (htrans == 2'b10 && hready) dph_addr <= haddr;
    end
    assign hrdata = (dph_addr == 32'h10) ? rd_int :
                    (dph_addr == 32'h18) ? rd_err : 32'hDEAD_BEEF;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge hclk);
        #1;
    endtask

    task automatic edge_idle;
        nxt;
        intr_in = 1'b1;
        #1;
        chk("edge_idle_htrans", 32'(htrans), 32'd0);
        n0 = cyc;
    endtask

    task automatic seq(input logic [31:0] iv, input logic [31:0] ev,
                       input logic [1:0] ecause, input int astall,
                       input int dstall, input bit ack, input bit reedge);
        int a0;
        a0 = 0;
        rd_int = iv;
        rd_err = ev;
        for (int s = 0; s <= astall; s++) begin
            nxt;
            intr_in = 1'b0;
            hready = (s == astall);
            #1;
            if (s == 0) a0 = cyc;
            chk("rdint_a_htrans", 32'(htrans), 32'd2);
            chk("rdint_a_haddr", haddr, 32'h10);
            chk("rdint_a_hwrite", 32'(hwrite), 32'd0);
        end
        for (int s = 0; s <= dstall; s++) begin
            nxt;
            hready = (s == dstall);
            #1;
            chk("rdint_d_htrans", 32'(htrans), 32'd0);
            chk("rdint_d_valid", 32'(evt_valid), 32'd0);
        end
        if (ERR) begin
            nxt;
            #1;
            chk("rderr_a_htrans", 32'(htrans), 32'd2);
            chk("rderr_a_haddr", haddr, 32'h18);
            nxt;
            #1;
            chk("rderr_d_htrans", 32'(htrans), 32'd0);
        end
        nxt;
        evt_ready = ack;
        intr_in = reedge;
        #1;
        chk("evt_valid", 32'(evt_valid), 32'd1);
        chk("evt_latency", 32'(cyc - a0), 32'(2 + astall + dstall + XE));
        chk("evt_intr", evt_intr, iv);
        chk("evt_err", evt_err, ERR ? ev : 32'd0);
        chk("evt_cause", 32'(evt_cause), 32'(ecause));
        chk("evt_dropped_first", 32'(evt_dropped), 32'd0);
        if (!ack) begin
            for (int k = 1; k < 4; k++) begin
                nxt;
                #1;
                chk("evt_hold_valid", 32'(evt_valid), 32'd1);
                chk("evt_hold_intr", evt_intr, iv);
                chk("evt_dropped", 32'(evt_dropped), 32'(k == 3));
            end
        end
        nxt;
        evt_ready = 1'b0;
        #1;
        chk("wrclr_a_htrans", 32'(htrans), 32'd2);
        chk("wrclr_a_haddr", haddr, 32'h14);
        chk("wrclr_a_hwrite", 32'(hwrite), 32'd1);
        chk("wrclr_a_valid", 32'(evt_valid), 32'd0);
        chk("wrclr_a_dropped", 32'(evt_dropped), 32'd0);
        nxt;
        #1;
        chk("wrclr_d_htrans", 32'(htrans), 32'd0);
        chk("wrclr_d_hwdata", hwdata, 32'd1);
        if (ERR) begin
            nxt;
            #1;
            chk("wrerr_a_htrans", 32'(htrans), 32'd2);
            chk("wrerr_a_haddr", haddr, 32'h1C);
            chk("wrerr_a_hwrite", 32'(hwrite), 32'd1);
            nxt;
            #1;
            chk("wrerr_d_hwdata", hwdata, 32'd1);
        end
        nxt;
        #1;
        chk("back_idle_htrans", 32'(htrans), 32'd0);
        chk("back_idle_hwdata", hwdata, 32'd0);
    endtask

    initial begin
        hreset = 1'b1;
        intr_in = 1'b0;
        hready = 1'b1;
        hresp = 1'b0;
        evt_ready = 1'b0;
        rd_int = '0;
        rd_err = '0;
        repeat (2) nxt;
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_hsize", 32'(hsize), 32'd2);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_intr", evt_intr, 32'd0);
        chk("rst_evt_err", evt_err, 32'd0);
        chk("rst_evt_cause", 32'(evt_cause), 32'd0);
        chk("rst_dropped", 32'(evt_dropped), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        hreset = 1'b0;

        edge_idle;
        seq(32'h1, 32'h0, 2'b10, 0, 0, 1'b1, 1'b0);
        nxt;
        #1;
        chk("no_pending_idle", 32'(htrans), 32'd0);

        edge_idle;
        seq(32'h1, 32'h3, ERR ? 2'b11 : 2'b10, 0, 0, 1'b1, 1'b0);

        edge_idle;
        seq(32'h4, 32'h0, 2'b00, 2, 3, 1'b1, 1'b0);

        edge_idle;
        seq(32'h1, 32'h0, 2'b10, 0, 0, 1'b0, 1'b0);

        edge_idle;
        rd_int = 32'h7;
        nxt;
        intr_in = 1'b0;
        #1;
        chk("berr_a_htrans", 32'(htrans), 32'd2);
        nxt;
        hresp = 1'b1;
        #1;
        chk("berr_pulse", 32'(bus_err), 32'd1);
        nxt;
        hresp = 1'b0;
        #1;
        chk("berr_idle_htrans", 32'(htrans), 32'd0);
        chk("berr_pulse_end", 32'(bus_err), 32'd0);
        chk("berr_no_update", evt_intr, 32'h1);
        seq(32'h1, 32'h0, 2'b10, 0, 0, 1'b1, 1'b1);
        seq(32'h2, 32'h0, 2'b00, 0, 0, 1'b1, 1'b0);

        edge_idle;
        nxt;
        #1;
        chk("mid_a_htrans", 32'(htrans), 32'd2);
        hreset = 1'b1;
        intr_in = 1'b0;
        nxt;
        hreset = 1'b0;
        #1;
        chk("mid_rst_htrans", 32'(htrans), 32'd0);
        chk("mid_rst_intr", evt_intr, 32'd0);
        chk("mid_rst_cause", 32'(evt_cause), 32'd0);
        nxt;
        #1;
        chk("mid_rst_stay_idle", 32'(htrans), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
